riscv_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported 32-bit block RAM behind the Riscv151 core between the instruction-fetch stage and the data-memory stage. It grants at most one access per cycle, routes the one-cycle-latency read data back to its owner, and drives the core's stall signal while a requester is held off. Fixed data-over-instruction priority, optionally bounded by a starvation guard.

---
 rtl/riscv_mem_arbiter.sv | 99 +++++++++
 tb/tb_riscv_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-ported 32-bit RAM between instruction fetch and data access.
// Optional starvation guard for fetch is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module riscv_mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall
);

  logic i_rvalid_q, i_rvalid_d;
  logic d_rvalid_q, d_rvalid_d;
  logic fetch_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q, starve_d;

  assign fetch_force = (starve_q == STARVE_LIM);

  // Counts consecutive cycles fetch was held off; any fetch grant or idle fetch clears it.
  always_comb begin
    starve_d = 4'd0;
    if (!rst && i_req && !i_gnt) begin
      starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= 4'd0;
    else     starve_q <= starve_d;
  end
`else
  assign fetch_force = 1'b0;
`endif

  // Data wins unless the starvation guard forces fetch this cycle; nothing is granted in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (i_req && (fetch_force || !d_req)) i_gnt = 1'b1;
      else if (d_req)                       d_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt ? d_we : 4'b0000;
    mem_addr  = d_gnt ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
    mem_wdata = d_wdata;
    stall     = !rst && ((i_req && !i_gnt) || (d_req && !d_gnt));
  end

  // Owner of the access made this cycle; data writes return nothing.
  always_comb begin
    i_rvalid_d = i_gnt;
    d_rvalid_d = d_gnt && (d_we == 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  // Byte-offset and out-of-range address bits are intentionally discarded (RAM wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a behavioural RAM and a read-data scoreboard.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_riscv_mem_arbiter;
  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req;
  logic [31:0]       i_addr, d_addr, d_wdata;
  logic [3:0]        d_we;
  logic              i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0]       i_rdata, d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];          // {owner is data, expected read data}
  logic [31:0] shadow[int];
  logic [31:0] ram[0:(1<<ADDR_W)-1];

  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  // Clock and behavioural single-port RAM with one-cycle read latency
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << ADDR_W) - 1));
  endfunction

  function automatic logic [31:0] shadow_rd(input int i);
    return shadow.exists(i) ? shadow[i] : 32'h0;
  endfunction

  // One clock cycle: drive, check grant-phase outputs, then check returned data after the edge.
  task automatic cycle(input logic xr, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic eig, input logic edg);
    logic exp_iv, exp_dv;
    logic [32:0] e;
    logic [31:0] w;
    rst = xr; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    #2;
    chk("i_gnt", i_gnt, eig);
    chk("d_gnt", d_gnt, edg);
    chk("stall", stall, !xr && ((ir && !eig) || (dr && !edg)));
    chk("mem_en", mem_en, eig | edg);
    if (edg) begin
      chk("mem_addr_d", mem_addr, widx(da));
      chk("mem_we_d", mem_we, dw);
      if (dw != 4'b0000) begin
        chk("mem_wdata", mem_wdata, dwd);
        w = shadow_rd(widx(da));
        for (int b = 0; b < 4; b++) if (dw[b]) w[8*b +: 8] = dwd[8*b +: 8];
        shadow[widx(da)] = w;
      end else begin
        exp_q.push_back({1'b1, shadow_rd(widx(da))});
      end
    end else if (eig) begin
      chk("mem_addr_i", mem_addr, widx(ia));
      chk("mem_we_i", mem_we, 4'b0000);
      exp_q.push_back({1'b0, shadow_rd(widx(ia))});
    end else begin
      chk("mem_we_idle", mem_we, 4'b0000);
    end
    exp_iv = eig;
    exp_dv = edg && (dw == 4'b0000);
    @(posedge clk); #1;
    chk("i_rvalid", i_rvalid, exp_iv);
    chk("d_rvalid", d_rvalid, exp_dv);
    if ((exp_iv || exp_dv) && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[32]) chk("d_rdata", d_rdata, e[31:0]);
      else       chk("i_rdata", i_rdata, e[31:0]);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1;
    // Reset: requests present but nothing granted, nothing returned
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0,  1'b0, 4'b0000, 32'h0,  32'h0, 1'b0, 1'b0);
    idle();

    // Load instruction word 4, then fetch it (plain and with wrapped/unaligned address)
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 4'b1111, 32'h10, 32'h00700093, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'hFFFF0013, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);

    // Data write then read of word 8
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 4'b1111, 32'h20, 32'h80000001, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b1);

    // Byte write into an all-ones word
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 4'b1111, 32'h20, 32'hFFFFFFFF, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 4'b0010, 32'h20, 32'h0000AB00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b1);
    chk("byte_merge", shadow_rd(8), 32'hFFFFABFF);

    // Back-to-back grants to alternating owners
    cycle(1'b0, 1'b0, 32'h0,  1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 4'b0000, 32'h0,  32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0,  1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b1);

    // Conflict: data wins, then idle clears any starvation count
    cycle(1'b0, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b1);
    idle();

    // Sustained conflict: with the guard, fetch wins every fifth cycle
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h20, 32'h0,
            GUARD && (k % 5 == 4), !(GUARD && (k % 5 == 4)));
    end
    idle();

    // Build up starvation count, reset mid-read, then the count must restart from zero
    cycle(1'b0, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h20, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, 32'h10, 1'b1, 4'b0000, 32'h20, 32'h0,
            GUARD && (k == 4), !(GUARD && (k == 4)));
    end
    idle();
    idle();

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
